// File: rtl/id_ex_operand_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_pkg
// Shared Falco types for the decode-to-execute operand stage:
//   xlen_data_t     - datapath word
//   reg_addr_t      - architectural register index
//   alu_op_t        - ALU operation encoding
//   id_ex_bundle_t  - decoded fields held by the ID/EX register
//   addr_match()    - register-index compare that never matches x0
// -----------------------------------------------------------------------------
package id_ex_operand_stage_pkg;

   localparam int XLEN_W    = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [XLEN_W-1:0]     xlen_data_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SR  = 3'd7
   } alu_op_t;

   typedef struct packed {
      xlen_data_t pc;
      reg_addr_t  rs1_addr;
      reg_addr_t  rs2_addr;
      xlen_data_t imm;
      logic       use_pc;
      logic       use_imm;
      alu_op_t    alu_op;
      logic       shift_sel;
      reg_addr_t  rd_addr;
      logic       reg_write;
      logic       is_load;
   } id_ex_bundle_t;

   localparam id_ex_bundle_t ID_EX_BUNDLE_RESET = '0;

   // x0 is hardwired to zero, so a producer writing x0 never matches a source.
   function automatic logic addr_match(input reg_addr_t a, input reg_addr_t b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/id_ex_operand_stage_operand_forward.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_operand_forward
// Per-source forward mux and load-use compare for one held operand.
//   rs_addr_i / held_data_i   - held source index and its operand register
//   rs_used_i                 - source participates in the hazard check
//   mem_* / wb_*              - producer info from the MEM and WB stages
//   fwd_data_o                - forwarded operand (0 for x0)
//   load_hit_o                - MEM-stage load targets this source
//   wb_hit_o                  - WB write targets this source (used for refresh)
// -----------------------------------------------------------------------------
module id_ex_operand_stage_operand_forward
   import id_ex_operand_stage_pkg::*;
(
   input  reg_addr_t  rs_addr_i,
   input  xlen_data_t held_data_i,
   input  logic       rs_used_i,
   input  logic       mem_valid_i,
   input  logic       mem_reg_write_i,
   input  logic       mem_is_load_i,
   input  reg_addr_t  mem_rd_addr_i,
   input  xlen_data_t mem_data_i,
   input  logic       wb_valid_i,
   input  logic       wb_reg_write_i,
   input  reg_addr_t  wb_rd_addr_i,
   input  xlen_data_t wb_data_i,
   output xlen_data_t fwd_data_o,
   output logic       load_hit_o,
   output logic       wb_hit_o
);

   logic mem_fwd;
   logic mem_write_match;

   // Producer matches; a MEM load has no data yet, so it stalls instead of forwarding.
   always_comb begin
      mem_write_match = mem_valid_i & mem_reg_write_i & addr_match(mem_rd_addr_i, rs_addr_i);
      mem_fwd         = mem_write_match & ~mem_is_load_i;
      load_hit_o      = rs_used_i & mem_write_match & mem_is_load_i;
      wb_hit_o        = wb_valid_i & wb_reg_write_i & addr_match(wb_rd_addr_i, rs_addr_i);
   end

   // Forward mux: x0 first, then the younger MEM result, then WB, then the held value.
   always_comb begin
      fwd_data_o = held_data_i;
      if (rs_addr_i == '0) begin
         fwd_data_o = '0;
      end else if (mem_fwd) begin
         fwd_data_o = mem_data_i;
      end else if (wb_hit_o) begin
         fwd_data_o = wb_data_i;
      end else begin
         fwd_data_o = held_data_i;
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
// Falco ID/EX pipeline register feeding the ALU. Holds one decoded instruction,
// forwards operands from MEM/WB, stalls on load-use and supports flush.
//   clk, rst                  - clock, asynchronous active-high reset
//   in_*                      - decoded instruction with valid/ready handshake
//   flush                     - kill the held instruction and drop any incoming one
//   mem_*, wb_*               - producer info for forwarding and hazard detection
//   out_valid / out_ready     - handshake towards execute
//   alu_a, alu_b, alu_op, shift_sel, store_data, out_*  - execute operands/fields
//   hazard_stall              - load-use stall active
// -----------------------------------------------------------------------------
module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    in_pc,
   input  logic [RADDR_W-1:0] in_rs1_addr,
   input  logic [RADDR_W-1:0] in_rs2_addr,
   input  logic [XLEN-1:0]    in_rs1_data,
   input  logic [XLEN-1:0]    in_rs2_data,
   input  logic [XLEN-1:0]    in_imm,
   input  logic               in_use_pc,
   input  logic               in_use_imm,
   input  logic [2:0]         in_alu_op,
   input  logic               in_shift_sel,
   input  logic [RADDR_W-1:0] in_rd_addr,
   input  logic               in_reg_write,
   input  logic               in_is_load,
   input  logic               flush,
   input  logic               mem_valid,
   input  logic               mem_reg_write,
   input  logic               mem_is_load,
   input  logic [RADDR_W-1:0] mem_rd_addr,
   input  logic [XLEN-1:0]    mem_data,
   input  logic               wb_valid,
   input  logic               wb_reg_write,
   input  logic [RADDR_W-1:0] wb_rd_addr,
   input  logic [XLEN-1:0]    wb_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    alu_a,
   output logic [XLEN-1:0]    alu_b,
   output logic [2:0]         alu_op,
   output logic               shift_sel,
   output logic [XLEN-1:0]    store_data,
   output logic [XLEN-1:0]    out_pc,
   output logic [RADDR_W-1:0] out_rd_addr,
   output logic               out_reg_write,
   output logic               out_is_load,
   output logic               hazard_stall
);

   id_ex_bundle_t held_q, held_d;
   xlen_data_t    rs1_data_q, rs1_data_d;
   xlen_data_t    rs2_data_q, rs2_data_d;
   logic          valid_q, valid_d;

   xlen_data_t    fwd_rs1, fwd_rs2;
   logic          rs1_load_hit, rs2_load_hit;
   logic          rs1_wb_hit, rs2_wb_hit;
   logic          capture, fire;

   // rs1 is irrelevant to the hazard when operand a is the PC; rs2 always feeds store_data.
   id_ex_operand_stage_operand_forward u_fwd_rs1 (
      .rs_addr_i       (held_q.rs1_addr),
      .held_data_i     (rs1_data_q),
      .rs_used_i       (~held_q.use_pc),
      .mem_valid_i     (mem_valid),
      .mem_reg_write_i (mem_reg_write),
      .mem_is_load_i   (mem_is_load),
      .mem_rd_addr_i   (mem_rd_addr),
      .mem_data_i      (mem_data),
      .wb_valid_i      (wb_valid),
      .wb_reg_write_i  (wb_reg_write),
      .wb_rd_addr_i    (wb_rd_addr),
      .wb_data_i       (wb_data),
      .fwd_data_o      (fwd_rs1),
      .load_hit_o      (rs1_load_hit),
      .wb_hit_o        (rs1_wb_hit)
   );

   id_ex_operand_stage_operand_forward u_fwd_rs2 (
      .rs_addr_i       (held_q.rs2_addr),
      .held_data_i     (rs2_data_q),
      .rs_used_i       (1'b1),
      .mem_valid_i     (mem_valid),
      .mem_reg_write_i (mem_reg_write),
      .mem_is_load_i   (mem_is_load),
      .mem_rd_addr_i   (mem_rd_addr),
      .mem_data_i      (mem_data),
      .wb_valid_i      (wb_valid),
      .wb_reg_write_i  (wb_reg_write),
      .wb_rd_addr_i    (wb_rd_addr),
      .wb_data_i       (wb_data),
      .fwd_data_o      (fwd_rs2),
      .load_hit_o      (rs2_load_hit),
      .wb_hit_o        (rs2_wb_hit)
   );

   // Handshake and ALU-facing outputs; flush deliberately does not touch in_ready.
   always_comb begin
      hazard_stall  = valid_q & (rs1_load_hit | rs2_load_hit);
      out_valid     = valid_q & ~hazard_stall;
      in_ready      = ~valid_q | (out_ready & ~hazard_stall);
      capture       = in_valid & in_ready;
      fire          = out_valid & out_ready;
      alu_a         = held_q.use_pc  ? held_q.pc  : fwd_rs1;
      alu_b         = held_q.use_imm ? held_q.imm : fwd_rs2;
      store_data    = fwd_rs2;
      alu_op        = held_q.alu_op;
      shift_sel     = held_q.shift_sel;
      out_pc        = held_q.pc;
      out_rd_addr   = held_q.rd_addr;
      out_reg_write = held_q.reg_write;
      out_is_load   = held_q.is_load;
   end

   // Next state: capture a new instruction, or refresh held operands from WB so a
   // retiring producer's value survives after it leaves the forwarding window.
   always_comb begin
      held_d     = held_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      if (capture && !flush) begin
         held_d.pc        = in_pc;
         held_d.rs1_addr  = in_rs1_addr;
         held_d.rs2_addr  = in_rs2_addr;
         held_d.imm       = in_imm;
         held_d.use_pc    = in_use_pc;
         held_d.use_imm   = in_use_imm;
         held_d.alu_op    = alu_op_t'(in_alu_op);
         held_d.shift_sel = in_shift_sel;
         held_d.rd_addr   = in_rd_addr;
         held_d.reg_write = in_reg_write;
         held_d.is_load   = in_is_load;
         rs1_data_d       = in_rs1_data;
         rs2_data_d       = in_rs2_data;
      end else if (valid_q) begin
         if (rs1_wb_hit) begin
            rs1_data_d = wb_data;
         end else begin
            rs1_data_d = rs1_data_q;
         end
         if (rs2_wb_hit) begin
            rs2_data_d = wb_data;
         end else begin
            rs2_data_d = rs2_data_q;
         end
      end else begin
         held_d = held_q;
      end

      if (flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d = 1'b1;
      end else if (fire) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         held_q     <= ID_EX_BUNDLE_RESET;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
      end else begin
         valid_q    <= valid_d;
         held_q     <= held_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
      end
   end

endmodule
